inv_sched: RTL

- Scheduler that shares one GF(2^N) field inverter core (poly x^5+x^2+1 at N=5) among NREQ requesters, e.g. point-add/double units.
- Per operation it round-robin arbitrates, re-initialises the core through its active-low reset, loads the operand, and waits for done.
- Returns the inverse tagged with the requester ID.
- Guards against zero operands and hung operations with an error flag.

---
 rtl/inv_sched_pkg.sv | 21 ++
 rtl/inv_sched_if.sv | 31 +++
 rtl/inv_sched_rr_arbiter.sv | 39 +++
 rtl/inv_sched.sv | 135 +++++++++++++
 4 files changed

// File: rtl/inv_sched_pkg.sv
// Shared definitions for the GF(2^N) inverter scheduler.
// Holds the FSM state encoding, the field width and reduction polynomial the
// external inverter core is built for, and the default RUN-state abort limit.
package inv_sched_pkg;

  // Field GF(2^5) with reduction polynomial x^5 + x^2 + 1.
  localparam int              FIELD_N    = 5;
  localparam logic [FIELD_N:0] FIELD_POLY = 6'b100101;

  // Default abort limit for RUN; it must cover the core latency (>= 4N+8).
  localparam int DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_LOAD = 3'd2,
    ST_RUN  = 3'd3,
    ST_RSP  = 3'd4
  } state_e;

endpackage

// File: rtl/inv_sched_if.sv
// Requester/response bus of the inverter scheduler.
//   REQ_VALID [NREQ]   : per-requester request
//   REQ_A     [NREQ*N] : operands, requester i at [i*N +: N]
//   REQ_READY [NREQ]   : one-hot grant pulse
//   RSP_VALID/RSP_READY: response handshake
//   RSP_ID/RSP_DATA/RSP_ERR : tagged result
// master = requester side, slave = scheduler side.
interface inv_sched_if #(
  parameter int N    = 5,
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]   REQ_VALID;
  logic [NREQ*N-1:0] REQ_A;
  logic [NREQ-1:0]   REQ_READY;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [IDW-1:0]    RSP_ID;
  logic [N-1:0]      RSP_DATA;
  logic              RSP_ERR;

  modport master (
    output REQ_VALID, REQ_A, RSP_READY,
    input  REQ_READY, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR
  );

  modport slave (
    input  REQ_VALID, REQ_A, RSP_READY,
    output REQ_READY, RSP_VALID, RSP_ID, RSP_DATA, RSP_ERR
  );
endinterface

// File: rtl/inv_sched_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req [NREQ] : request vector
//   ptr [IDW]  : index of the last winner; search starts at ptr+1
//   en         : arbitration enable (grant forced to zero when low)
//   gnt [NREQ] : one-hot grant
//   idx [IDW]  : index of the granted requester
//   any        : a grant was issued
// The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any
);
  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    if (en) begin
      // Walk ptr+1 .. ptr+NREQ (mod NREQ); the first hit wins.
      for (int k = 1; k <= NREQ; k++) begin
        j = (int'(ptr) + k) % NREQ;
        if (!any && req[j]) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IDW'(j);
        end
      end
    end
  end
endmodule

// File: rtl/inv_sched.sv
// Shares one GF(2^N) inverter core among NREQ requesters.
// Per operation: round-robin grant, reset the core, load the operand, wait
// for done (or abort on timeout), return the inverse tagged with the
// requester ID. A zero operand skips the core and returns an error.
//   CLK, RST        : clock, synchronous active-high reset
//   bus (slave)     : requester/response handshake
//   BUSY            : FSM not idle
//   LAST_CYC [CW]   : RUN cycles of the last completed op (saturating)
//   INV_RST_N       : core reset, active-low
//   INV_A [N]       : core operand, INV_IN_VALID its load strobe
//   INV_OUT [N]     : core result, INV_OUT_VALID done level
module inv_sched
  import inv_sched_pkg::*;
#(
  parameter int N       = FIELD_N,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CW      = 8
) (
  input  logic          CLK,
  input  logic          RST,
  inv_sched_if.slave    bus,
  output logic          BUSY,
  output logic [CW-1:0] LAST_CYC,
  output logic          INV_RST_N,
  output logic [N-1:0]  INV_A,
  output logic          INV_IN_VALID,
  input  logic [N-1:0]  INV_OUT,
  input  logic          INV_OUT_VALID
);
  localparam int              CNTW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);
  localparam int              SAT      = (1 << CW) - 1;

  state_e          state, nxt;
  logic [IDW-1:0]  ptr, id, gidx;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic [N-1:0]    op, gop, rsp_data;
  logic            rsp_err;
  logic [CNTW-1:0] cnt;
  logic [CW-1:0]   last_cyc;

  function automatic logic [CW-1:0] sat_cyc(input int v);
    return (v >= SAT) ? CW'(SAT) : CW'(v);
  endfunction

  // Grants only in IDLE and never while reset is asserted, so a requester
  // cannot be acknowledged by a cycle that is about to be discarded.
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req (bus.REQ_VALID),
    .ptr (ptr),
    .en  (state == ST_IDLE && !RST),
    .gnt (gnt),
    .idx (gidx),
    .any (any)
  );

  assign gop = bus.REQ_A[int'(gidx)*N +: N];

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= ST_IDLE;
    else     state <= nxt;
  end

  // Next state
  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE: if (any) nxt = (gop == '0) ? ST_RSP : ST_CLR;
      ST_CLR:  nxt = ST_LOAD;
      ST_LOAD: nxt = ST_RUN;
      ST_RUN:  if (INV_OUT_VALID || cnt == CNT_LAST) nxt = ST_RSP;
      ST_RSP:  if (bus.RSP_READY) nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.REQ_READY = gnt;
    bus.RSP_VALID = (state == ST_RSP);
    bus.RSP_ID    = id;
    bus.RSP_DATA  = rsp_data;
    bus.RSP_ERR   = rsp_err;
    BUSY          = (state != ST_IDLE);
    LAST_CYC      = last_cyc;
    // Core is held in reset by our own reset too, so an aborted op leaves
    // nothing running in the core.
    INV_RST_N     = ~(RST | (state == ST_CLR));
    INV_IN_VALID  = (state == ST_LOAD);
    INV_A         = (state == ST_LOAD) ? op : '0;
  end

  // Operation context, cycle counter and response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr      <= IDW'(NREQ - 1);
      id       <= '0;
      op       <= '0;
      cnt      <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      last_cyc <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any) begin
          ptr <= gidx;
          id  <= gidx;
          op  <= gop;
          if (gop == '0) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end
        end
        ST_LOAD: cnt <= '0;
        ST_RUN: begin
          cnt <= cnt + 1'b1;
          if (INV_OUT_VALID) begin
            rsp_data <= INV_OUT;
            rsp_err  <= 1'b0;
            last_cyc <= sat_cyc(int'(cnt) + 1);
          end else if (cnt == CNT_LAST) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
            last_cyc <= sat_cyc(TIMEOUT);
          end
        end
        default: ;
      endcase
    end
  end
endmodule
